// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (I) and the memory-access stage (D).
// D has priority with an I-starvation limit; one transaction in flight; flushed I responses are dropped.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_D_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req_valid,
    output logic                i_req_ready,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                i_flush,
    output logic                i_rsp_valid,
    output logic [DATA_W-1:0]   i_rsp_data,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic                d_we,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_rsp_valid,
    output logic [DATA_W-1:0]   d_rsp_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data
);

    localparam int STRB_W   = DATA_W / 8;
    localparam int STREAK_W = $clog2(MAX_D_BURST + 1);
    localparam logic OWNER_D = 1'b0;
    localparam logic OWNER_I = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic                  owner_r;
    logic                  discard_r;
    logic [STREAK_W-1:0]   d_streak_r;
    logic [ADDR_W-1:0]     mem_addr_r;
    logic                  mem_we_r;
    logic [DATA_W-1:0]     mem_wdata_r;
    logic [STRB_W-1:0]     mem_wstrb_r;

    logic                  i_elig_s;
    logic                  streak_full_s;
    logic                  d_win_s;
    logic                  i_win_s;
    logic                  i_req_ready_s;
    logic                  d_req_ready_s;
    logic                  mem_req_valid_s;
    logic                  i_rsp_valid_s;
    logic                  d_rsp_valid_s;

    // A flushing fetch may not win; once D has won MAX_D_BURST times in a row over a waiting I, I takes a turn.
    assign i_elig_s      = i_req_valid && !i_flush;
    assign streak_full_s = (d_streak_r == STREAK_W'(MAX_D_BURST));
    assign d_win_s       = d_req_valid && !(i_elig_s && streak_full_s);
    assign i_win_s       = i_elig_s && !d_win_s;

    assign i_req_ready   = i_req_ready_s;
    assign d_req_ready   = d_req_ready_s;
    assign mem_req_valid = mem_req_valid_s;
    assign i_rsp_valid   = i_rsp_valid_s;
    assign d_rsp_valid   = d_rsp_valid_s;
    assign i_rsp_data    = mem_rsp_data;
    assign d_rsp_data    = mem_rsp_data;
    assign mem_addr      = mem_addr_r;
    assign mem_we        = mem_we_r;
    assign mem_wdata     = mem_wdata_r;
    assign mem_wstrb     = mem_wstrb_r;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (d_win_s || i_win_s) begin
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mem_req_ready) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (mem_rsp_valid) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs; a flush arriving with the response still suppresses the I pulse.
    always_comb begin
        i_req_ready_s   = 1'b0;
        d_req_ready_s   = 1'b0;
        mem_req_valid_s = 1'b0;
        i_rsp_valid_s   = 1'b0;
        d_rsp_valid_s   = 1'b0;
        if (rst) begin
            case (state_r)
                ST_IDLE: begin
                    i_req_ready_s = i_win_s;
                    d_req_ready_s = d_win_s;
                end
                ST_ISSUE: begin
                    mem_req_valid_s = 1'b1;
                end
                ST_WAIT: begin
                    if (mem_rsp_valid) begin
                        d_rsp_valid_s = (owner_r == OWNER_D);
                        i_rsp_valid_s = (owner_r == OWNER_I) && !discard_r && !i_flush;
                    end else begin
                        d_rsp_valid_s = 1'b0;
                        i_rsp_valid_s = 1'b0;
                    end
                end
                default: begin
                    mem_req_valid_s = 1'b0;
                end
            endcase
        end else begin
            i_req_ready_s = 1'b0;
            d_req_ready_s = 1'b0;
        end
    end

    // Request capture on grant: fields, owner and the D streak count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_r     <= OWNER_D;
            d_streak_r  <= '0;
            mem_addr_r  <= '0;
            mem_we_r    <= 1'b0;
            mem_wdata_r <= '0;
            mem_wstrb_r <= '0;
        end else if (state_r == ST_IDLE && d_win_s) begin
            owner_r     <= OWNER_D;
            mem_addr_r  <= d_addr;
            mem_we_r    <= d_we;
            mem_wdata_r <= d_wdata;
            mem_wstrb_r <= d_wstrb;
            if (!i_req_valid) begin
                d_streak_r <= '0;
            end else if (!streak_full_s) begin
                d_streak_r <= d_streak_r + STREAK_W'(1);
            end
        end else if (state_r == ST_IDLE && i_win_s) begin
            owner_r     <= OWNER_I;
            d_streak_r  <= '0;
            mem_addr_r  <= i_addr;
            mem_we_r    <= 1'b0;
            mem_wdata_r <= '0;
            mem_wstrb_r <= '0;
        end
    end

    // Discard flag: remembers a flush seen while an I transaction is outstanding.
    always_ff @(posedge clk) begin
        if (!rst) begin
            discard_r <= 1'b0;
        end else if (state_r == ST_IDLE || (state_r == ST_WAIT && mem_rsp_valid)) begin
            discard_r <= 1'b0;
        end else if (owner_r == OWNER_I && i_flush) begin
            discard_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: reset checks, an arbitration vector table, directed corner
// sequences, and randomized traffic checked against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;
    localparam int MAXB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req_valid, i_req_ready, i_flush, i_rsp_valid;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rsp_data;
    logic          d_req_valid, d_req_ready, d_we, d_rsp_valid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rsp_data;
    logic [SW-1:0] d_wstrb;
    logic          mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rsp_data;
    logic [SW-1:0] mem_wstrb;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_BURST(MAXB)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
        .i_flush(i_flush), .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
        .d_we(d_we), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit iv;
        bit dv;
        bit fl;
        int win;   // 0 none, 1 D, 2 I
    } arb_vec_t;

    arb_vec_t tbl[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        i_req_valid = 1'b0; i_addr = '0; i_flush = 1'b0;
        d_req_valid = 1'b0; d_addr = '0; d_we = 1'b0; d_wdata = '0; d_wstrb = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    endtask

    // flush_mode: 0 none, 1 flush in the idle WAIT cycle, 2 flush together with the response
    task automatic run_txn(input bit is_i, input logic [AW-1:0] addr, input logic we,
                           input logic [DW-1:0] wdata, input logic [SW-1:0] wstrb,
                           input int stall, input int flush_mode,
                           input logic [DW-1:0] rdata, input bit exp_rsp, input string tag);
        if (is_i) begin
            i_req_valid = 1'b1; i_addr = addr;
        end else begin
            d_req_valid = 1'b1; d_addr = addr; d_we = we; d_wdata = wdata; d_wstrb = wstrb;
        end
        settle();
        chk({tag, "_i_ready"}, i_req_ready, is_i);
        chk({tag, "_d_ready"}, d_req_ready, !is_i);
        step();
        if (is_i) i_req_valid = 1'b0;
        else d_req_valid = 1'b0;
        for (int s = 0; s <= stall; s++) begin
            mem_req_ready = (s == stall);
            settle();
            chk({tag, "_mem_valid"}, mem_req_valid, 1'b1);
            chk({tag, "_mem_addr"}, mem_addr, addr);
            chk({tag, "_mem_we"}, mem_we, is_i ? 1'b0 : we);
            chk({tag, "_mem_wstrb"}, mem_wstrb, is_i ? 4'h0 : wstrb);
            if (!is_i) chk({tag, "_mem_wdata"}, mem_wdata, wdata);
            chk({tag, "_ready_busy"}, i_req_ready | d_req_ready, 1'b0);
            step();
        end
        mem_req_ready = 1'b0;
        i_flush = (flush_mode == 1);
        settle();
        chk({tag, "_rsp_early"}, i_rsp_valid | d_rsp_valid, 1'b0);
        step();
        mem_rsp_valid = 1'b1; mem_rsp_data = rdata; i_flush = (flush_mode == 2);
        settle();
        chk({tag, "_i_rsp"}, i_rsp_valid, is_i && exp_rsp);
        chk({tag, "_d_rsp"}, d_rsp_valid, !is_i && exp_rsp);
        if (exp_rsp) chk({tag, "_rsp_data"}, is_i ? i_rsp_data : d_rsp_data, rdata);
        step();
        mem_rsp_valid = 1'b0; i_flush = 1'b0;
        settle();
        chk({tag, "_rsp_after"}, i_rsp_valid | d_rsp_valid, 1'b0);
        chk({tag, "_idle"}, mem_req_valid, 1'b0);
    endtask

    // Transaction-level reference model state
    int            m_streak;
    bit            m_busy, m_issued, m_own_i, m_drop;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_wstrb;
    logic          m_we;

    initial begin
        bit i_ok, i_turn, exp_ir, exp_dr, exp_mv, exp_irsp, exp_drsp;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 2};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 2};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 0};

        // Reset: readies held low even with both requesters valid
        clear_inputs();
        rst = 1'b0;
        #1;
        i_req_valid = 1'b1; d_req_valid = 1'b1;
        settle();
        chk("rst_i_ready", i_req_ready, 1'b0);
        chk("rst_d_ready", d_req_ready, 1'b0);
        step();
        step();
        clear_inputs();
        rst = 1'b1;
        settle();
        chk("rst_mem_valid", mem_req_valid, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_fields", {mem_we, mem_wdata, mem_wstrb}, 37'h0);
        chk("rst_rsp", i_rsp_valid | d_rsp_valid, 1'b0);
        step();

        // Arbitration table, including streak saturation while I is flushing
        for (int k = 0; k < 11; k++) begin
            i_req_valid = tbl[k].iv; i_addr = 32'h8000_0000 + 32'(k * 4);
            d_req_valid = tbl[k].dv; d_addr = 32'h0000_1000 + 32'(k); d_we = 1'b0;
            i_flush = tbl[k].fl;
            settle();
            chk($sformatf("tbl%0d_d_ready", k), d_req_ready, tbl[k].win == 1);
            chk($sformatf("tbl%0d_i_ready", k), i_req_ready, tbl[k].win == 2);
            step();
            i_req_valid = 1'b0; d_req_valid = 1'b0; i_flush = 1'b0;
            if (tbl[k].win != 0) begin
                mem_req_ready = 1'b1;
                settle();
                chk($sformatf("tbl%0d_mem_valid", k), mem_req_valid, 1'b1);
                chk($sformatf("tbl%0d_mem_addr", k), mem_addr,
                    tbl[k].win == 1 ? 32'h0000_1000 + 32'(k) : 32'h8000_0000 + 32'(k * 4));
                step();
                mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hA500_0000 + 32'(k);
                settle();
                chk($sformatf("tbl%0d_d_rsp", k), d_rsp_valid, tbl[k].win == 1);
                chk($sformatf("tbl%0d_i_rsp", k), i_rsp_valid, tbl[k].win == 2);
                step();
                mem_rsp_valid = 1'b0;
            end
        end

        // I read
        run_txn(1'b1, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 0, 0, 32'h0010_0073, 1'b1, "iread");

        // Simultaneous: D store first, I waits and is granted at the next IDLE
        i_req_valid = 1'b1; i_addr = 32'h8000_0004;
        run_txn(1'b0, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'h0, 1'b1, "simul_d");
        run_txn(1'b1, 32'h8000_0004, 1'b0, 32'h0, 4'h0, 0, 0, 32'h1234_5678, 1'b1, "simul_i");

        // Flush in WAIT, flush with the response, then a normal fetch
        run_txn(1'b1, 32'h8000_0100, 1'b0, 32'h0, 4'h0, 0, 1, 32'h1111_1111, 1'b0, "flush_wait");
        run_txn(1'b1, 32'h8000_0104, 1'b0, 32'h0, 4'h0, 0, 2, 32'h2222_2222, 1'b0, "flush_same");
        run_txn(1'b1, 32'h8000_0200, 1'b0, 32'h0, 4'h0, 0, 0, 32'h3333_3333, 1'b1, "flush_next");

        // Flush with D owner is ignored
        run_txn(1'b0, 32'h0000_2000, 1'b0, 32'h0, 4'h3, 0, 2, 32'h4444_4444, 1'b1, "flush_d");

        // Backpressure: 5 stall cycles on a D load
        run_txn(1'b0, 32'h0000_3000, 1'b0, 32'h5555_AAAA, 4'h6, 5, 0, 32'h6666_6666, 1'b1, "bp");

        // Reset during WAIT, late response ignored, new request accepted
        step();
        i_req_valid = 1'b1; i_addr = 32'h8000_0010;
        step();
        i_req_valid = 1'b0; mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0; rst = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h7777_7777;
        d_req_valid = 1'b1;
        settle();
        chk("rstw_rsp_in_rst", i_rsp_valid | d_rsp_valid, 1'b0);
        chk("rstw_ready_in_rst", d_req_ready | i_req_ready, 1'b0);
        step();
        rst = 1'b1; d_req_valid = 1'b0;
        settle();
        chk("rstw_rsp_late", i_rsp_valid | d_rsp_valid, 1'b0);
        chk("rstw_mem_valid", mem_req_valid, 1'b0);
        step();
        mem_rsp_valid = 1'b0;
        run_txn(1'b0, 32'h0000_4000, 1'b0, 32'h0, 4'hF, 0, 0, 32'h8888_8888, 1'b1, "rstw_new");

        // Randomized traffic against the reference model
        clear_inputs();
        rst = 1'b0;
        step();
        rst = 1'b1;
        m_streak = 0; m_busy = 1'b0; m_issued = 1'b0; m_own_i = 1'b0; m_drop = 1'b0;
        m_addr = '0; m_wdata = '0; m_wstrb = '0; m_we = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!i_req_valid) begin
                i_req_valid = ($urandom % 3) != 0; i_addr = $urandom;
            end
            if (!d_req_valid) begin
                d_req_valid = ($urandom % 3) != 0; d_addr = $urandom;
                d_we = $urandom % 2; d_wdata = $urandom; d_wstrb = 4'($urandom);
            end
            i_flush = ($urandom % 6) == 0;
            mem_req_ready = $urandom % 2;
            mem_rsp_valid = ($urandom % 3) == 0;
            mem_rsp_data = $urandom;
            settle();

            exp_ir = 1'b0; exp_dr = 1'b0; exp_irsp = 1'b0; exp_drsp = 1'b0;
            exp_mv = m_busy && !m_issued;
            if (!m_busy) begin
                i_ok   = i_req_valid && !i_flush;
                i_turn = i_ok && (m_streak >= MAXB);
                exp_dr = d_req_valid && !i_turn;
                exp_ir = i_ok && !exp_dr;
            end else if (m_issued && mem_rsp_valid) begin
                if (m_own_i) exp_irsp = !(m_drop || i_flush);
                else exp_drsp = 1'b1;
            end

            chk("rnd_i_ready", i_req_ready, exp_ir);
            chk("rnd_d_ready", d_req_ready, exp_dr);
            chk("rnd_mem_valid", mem_req_valid, exp_mv);
            chk("rnd_i_rsp", i_rsp_valid, exp_irsp);
            chk("rnd_d_rsp", d_rsp_valid, exp_drsp);
            if (exp_mv) chk("rnd_mem_fields", {mem_addr, mem_we, mem_wstrb}, {m_addr, m_we, m_wstrb});
            if (exp_mv && m_we) chk("rnd_mem_wdata", mem_wdata, m_wdata);
            if (exp_irsp) chk("rnd_i_data", i_rsp_data, mem_rsp_data);
            if (exp_drsp) chk("rnd_d_data", d_rsp_data, mem_rsp_data);

            if (!m_busy) begin
                if (exp_dr) begin
                    m_busy = 1'b1; m_issued = 1'b0; m_own_i = 1'b0; m_drop = 1'b0;
                    m_addr = d_addr; m_we = d_we; m_wdata = d_wdata; m_wstrb = d_wstrb;
                    m_streak = i_req_valid ? ((m_streak < MAXB) ? m_streak + 1 : MAXB) : 0;
                end else if (exp_ir) begin
                    m_busy = 1'b1; m_issued = 1'b0; m_own_i = 1'b1; m_drop = 1'b0;
                    m_addr = i_addr; m_we = 1'b0; m_wdata = '0; m_wstrb = '0;
                    m_streak = 0;
                end
            end else if (!m_issued) begin
                if (mem_req_ready) m_issued = 1'b1;
                if (m_own_i && i_flush) m_drop = 1'b1;
            end else if (mem_rsp_valid) begin
                m_busy = 1'b0;
            end else if (m_own_i && i_flush) begin
                m_drop = 1'b1;
            end

            step();
            if (exp_dr) d_req_valid = 1'b0;
            if (exp_ir) i_req_valid = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
